muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, the multi-cycle companion to the single-cycle ALU. It executes MULT/MULTU/DIV/DIVU over WIDTH iterations under a start/busy/done handshake and services MTHI/MTLO writes in a single cycle. The core drives hi/lo straight to MFHI/MFLO result muxing and stalls on busy.

Parameters:
WIDTH, 32, operand width in bits; must be at least 4. hi and lo are each WIDTH bits.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
srca  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
srcb  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress; new start is ignored
done  output  1  one-cycle pulse; hi/lo hold the new result
div_by_zero  output  1  pulses with done when a DIV/DIVU had srcb=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: rst=1 asynchronously forces state IDLE, iteration counter 0, busy=0, done=0, div_by_zero=0, hi=0, lo=0.
- Reset mid-operation aborts the operation. No done pulse is produced.
- States:
  - IDLE: waits for a request.
  - ITER: one bit per cycle, using a shift-add multiplier or a restoring divider.
  - FIX: sign correction and HI/LO write.
- IDLE transitions:
  - start=1 with op in {MULT, MULTU, DIV, DIVU}: capture operand magnitudes and sign flags at edge k (signed ops only), then go to ITER.
  - start=1 with op=MTHI: write hi<=srca at edge k, stay IDLE, busy stays 0, no done pulse.
  - start=1 with op=MTLO: write lo<=srca at edge k, stay IDLE, busy stays 0, no done pulse.
  - start=1 with a reserved op: no state change.
- ITER: runs exactly WIDTH cycles (edges k+1 .. k+WIDTH), then goes to FIX.
- FIX, at edge k+WIDTH+1:
  - Write hi/lo, go to IDLE.
  - done=1 and div_by_zero registered for the single following cycle.
- Latency and handshake:
  - busy=1 in cycles after edges k .. k+WIDTH.
  - busy=0 in the done cycle, so back-to-back start is accepted while done=1.
  - Latency is start edge to done = WIDTH+1 edges, identical for every mul/div op and for divide-by-zero.
  - start while busy=1 is ignored; the operation in flight is unaffected.
  - hi/lo keep their old values until the FIX edge; intermediate values are never visible.
- Arithmetic:
  - MULTU: {hi,lo} = srca*srcb, unsigned, full 2*WIDTH-bit product.
  - MULT: two's-complement product. Multiply the magnitudes, then negate the 2*WIDTH result if the operand signs differ.
  - DIVU: lo = quotient, hi = remainder.
  - DIV: truncate toward zero. Quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
  - Signed overflow (most-negative / -1): lo = most-negative value, hi = 0. No flag is raised.
  - Divide by zero (DIV or DIVU): lo = all ones, hi = original srca, div_by_zero=1 with done. This holds regardless of sign.
- Operand capture: srca/srcb/op are captured at the start edge. Later changes on these inputs have no effect.

Test Plan:
- Reset mid-operation: start MULTU, assert rst at cycle 10 -> busy=0 and hi=lo=0 immediately; no done. Then MTLO 0x5 -> lo=0x5 the next cycle, busy stays 0.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, WIDTH=32 -> done exactly 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT -3 * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. A start pulsed during busy is ignored and the result is unchanged.
- Signed and unsigned divide:
  - DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100 / 7 -> lo=14, hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 for exactly the done cycle, same latency as a normal divide.
- Back-to-back and WIDTH=8:
  - MTHI 0xAB issued in the done cycle of a MULTU -> hi=0xAB on the following edge.
  - New start in the done cycle is accepted.
  - WIDTH=8, MULTU 255*255 -> {hi,lo}=0xFE01 after 9 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply or restoring divide, one bit per cycle, then one sign-fix/writeback cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is taken on a rising edge with start=1 and busy=0 (busy is
  // the inverse of ready); mul/div results appear with a one-cycle done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t state, next_state;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [WIDTH-1:0]   a_save;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;

  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && !op[2]) next_state = ITER;
      ITER:    if (cnt == LAST) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand conditioning and per-iteration arithmetic.
  always_comb begin
    sa        = ~op[0] & srca[WIDTH-1];
    sb        = ~op[0] & srcb[WIDTH-1];
    abs_a     = sa ? (-srca) : srca;
    abs_b     = sb ? (-srcb) : srcb;
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_reg} : '0);
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m_reg});
    div_diff  = div_shift - {1'b0, m_reg};
    prod      = {p_hi, p_lo};
    prod_fix  = neg_q ? (-prod) : prod;
    q_fix     = neg_q ? (-p_lo) : p_lo;
    r_fix     = neg_r ? (-p_hi) : p_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      m_reg       <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      a_save      <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              cnt    <= '0;
              is_div <= op[1];
              neg_q  <= sa ^ sb;
              neg_r  <= sa;
              a_save <= srca;
              p_hi   <= '0;
              if (op[1]) begin
                m_reg <= abs_b;
                p_lo  <= abs_a;
                dbz   <= (srcb == '0);
              end else begin
                m_reg <= abs_a;
                p_lo  <= abs_b;
                dbz   <= 1'b0;
              end
            end else if (op == OP_MTHI) begin
              hi <= srca;
            end else if (op == OP_MTLO) begin
              lo <= srca;
            end
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (div_ge) begin
              p_hi <= div_diff[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b1};
            end else begin
              p_hi <= div_shift[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            p_hi <= mul_sum[WIDTH:1];
            p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dbz;
          if (is_div) begin
            // Divide by zero reports all-ones quotient and the untouched dividend.
            if (dbz) begin
              hi <= a_save;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
